// File: rtl/apb_pkg.sv
// Types shared between the APB requester and the existing APB completer.
package apb_pkg;

    localparam int unsigned APB_ADDR_W = 32;
    localparam int unsigned APB_DATA_W = 32;
    localparam int unsigned WAIT_CNT_W = 8;

    typedef logic [APB_ADDR_W-1:0] addr_t;
    typedef logic [APB_DATA_W-1:0] data_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_operation_states;

endpackage

// File: rtl/apb_master.sv
// APB requester: turns a valid/ready command stream into APB transfers and
// returns one response pulse per transfer, aborting stalled ACCESS phases.
module apb_master
    import apb_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [ADDR_W-1:0] PADDR,
    output logic [DATA_W-1:0] PWDATA,
    input  logic              PREADY,
    input  logic [DATA_W-1:0] PRDATA
);

    localparam logic [WAIT_CNT_W-1:0] WAIT_LAST = WAIT_CNT_W'(TIMEOUT - 1);
    localparam logic [WAIT_CNT_W-1:0] WAIT_MAX  = WAIT_CNT_W'(TIMEOUT);

    apb_operation_states   state_q;
    logic                  psel_q;
    logic                  penable_q;
    logic                  pwrite_q;
    logic [ADDR_W-1:0]     paddr_q;
    logic [DATA_W-1:0]     pwdata_q;
    logic                  rsp_valid_q;
    logic                  rsp_err_q;
    logic [DATA_W-1:0]     rsp_rdata_q;
    logic [WAIT_CNT_W-1:0] wait_cnt_q;
    logic [WAIT_CNT_W-1:0] wait_cnt_d;

    logic in_access;
    logic timeout_hit;
    logic cmd_accept;

    // The abort fires on the edge that would take the counter to TIMEOUT.
    assign in_access   = (state_q == ACCESS);
    assign timeout_hit = in_access && !PREADY && (wait_cnt_q == WAIT_LAST);
    assign cmd_ready   = (state_q == IDLE) || (in_access && PREADY && !timeout_hit);
    assign cmd_accept  = cmd_valid && cmd_ready;

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (state_q == SETUP) begin
            wait_cnt_d = '0;
        end else if (in_access && !PREADY && (wait_cnt_q != WAIT_MAX)) begin
            wait_cnt_d = wait_cnt_q + WAIT_CNT_W'(1);
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q     <= IDLE;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            wait_cnt_q  <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            wait_cnt_q  <= wait_cnt_d;

            if (cmd_accept) begin
                paddr_q  <= cmd_addr;
                pwrite_q <= cmd_write;
                pwdata_q <= cmd_wdata;
            end

            case (state_q)
                IDLE: begin
                    if (cmd_valid) begin
                        state_q <= SETUP;
                        psel_q  <= 1'b1;
                    end
                end
                SETUP: begin
                    state_q   <= ACCESS;
                    penable_q <= 1'b1;
                end
                ACCESS: begin
                    if (PREADY) begin
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b0;
                        penable_q   <= 1'b0;
                        if (!pwrite_q) begin
                            rsp_rdata_q <= PRDATA;
                        end
                        // A command taken on the completing edge keeps PSEL high.
                        if (cmd_valid) begin
                            state_q <= SETUP;
                        end else begin
                            state_q <= IDLE;
                            psel_q  <= 1'b0;
                        end
                    end else if (timeout_hit) begin
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b1;
                        state_q     <= IDLE;
                        psel_q      <= 1'b0;
                        penable_q   <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    psel_q    <= 1'b0;
                    penable_q <= 1'b0;
                end
            endcase
        end
    end

    assign PSEL      = psel_q;
    assign PENABLE   = penable_q;
    assign PWRITE    = pwrite_q;
    assign PADDR     = paddr_q;
    assign PWDATA    = pwdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule

// File: doc/apb_master.md
APB_MASTER -- requirements
Module: apb_master

Interface
REQ-001 Parameter ADDR_W, default 32, PADDR and cmd_addr width.
REQ-002 Parameter DATA_W, default 32, PWDATA/PRDATA/cmd_wdata/rsp_rdata width.
REQ-003 Parameter TIMEOUT, default 16, maximum ACCESS cycles with PREADY low before abort; legal range 1..255.
REQ-004 PCLK  input  1  single clock; all logic rising-edge.
REQ-005 PRESETn  input  1  asynchronous, active-low reset.
REQ-006 cmd_valid  input  1  command request from local agent.
REQ-007 cmd_ready  output  1  command accepted when cmd_valid and cmd_ready are both high on a PCLK edge.
REQ-008 cmd_write  input  1  1 = write, 0 = read.
REQ-009 cmd_addr  input  ADDR_W  transfer address.
REQ-010 cmd_wdata  input  DATA_W  write data; ignored for reads.
REQ-011 rsp_valid  output  1  one-cycle pulse per completed or aborted transfer.
REQ-012 rsp_rdata  output  DATA_W  read data; valid with rsp_valid on reads.
REQ-013 rsp_err  output  1  1 = timeout abort; valid with rsp_valid.
REQ-014 PSEL, PENABLE, PWRITE  output  1 each  APB requester controls.
REQ-015 PADDR  output  ADDR_W; PWDATA  output  DATA_W.
REQ-016 PREADY  input  1; PRDATA  input  DATA_W  completer response.

Function
REQ-017 State machine uses apb_operation_states {IDLE, SETUP, ACCESS}.
REQ-018 IDLE: PSEL=0, PENABLE=0; cmd_ready=1; on accept, latch cmd_addr/cmd_write/cmd_wdata into PADDR/PWRITE/PWDATA, go SETUP.
REQ-019 SETUP: lasts exactly one cycle, PSEL=1, PENABLE=0, cmd_ready=0; next state ACCESS.
REQ-020 ACCESS: PSEL=1, PENABLE=1; PADDR/PWRITE/PWDATA held stable until PREADY sampled high or abort.
REQ-021 ACCESS with PREADY=1: transfer completes; rsp_valid=1 next cycle, rsp_err=0, rsp_rdata=PRDATA captured at that edge for reads, unchanged for writes.
REQ-022 cmd_ready = (state==IDLE) or (state==ACCESS and PREADY and not timeout); combinational.
REQ-023 Back-to-back: command accepted on completing ACCESS edge goes directly to SETUP with PSEL held 1, PENABLE 0; otherwise return to IDLE with PSEL=0.
REQ-024 Wait counter clears on entry to ACCESS, increments each ACCESS cycle with PREADY=0, saturates, never wraps.
REQ-025 Counter reaching TIMEOUT with PREADY still 0: abort; next cycle PSEL=0, PENABLE=0, state IDLE, rsp_valid=1, rsp_err=1, rsp_rdata unchanged; no command accepted on abort edge.
REQ-026 PREADY=1 on the same edge the counter reaches TIMEOUT: completion wins, rsp_err=0.
REQ-027 No response back-pressure: rsp_valid is a single-cycle pulse; consumer must sample it.
REQ-028 Minimum transfer latency: accept edge -> rsp_valid after 3 cycles with PREADY tied high in ACCESS.
REQ-029 PREADY/PRDATA ignored outside ACCESS.

Reset
REQ-030 PRESETn low asynchronously forces state=IDLE, PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, rsp_valid=0, rsp_err=0, rsp_rdata=0, counter=0.
REQ-031 Reset mid-transfer drops the transfer silently; no rsp_valid after reset release.
REQ-032 First command may be accepted on the first PCLK edge after PRESETn deasserts.

Structure
REQ-033 apb_operation_states, addr_t and data_t typedefs live in apb_pkg, shared with the existing completer.
REQ-034 APB pins grouped via the apb_if master modport at integration; ports above are its contents.
REQ-035 Single flat module; no sub-module.

Verification
REQ-036 Write 0x0000_0010 <= 0xDEAD_BEEF, PREADY high in first ACCESS cycle -> PSEL 2 cycles, PENABLE 1 cycle, rsp_valid with rsp_err=0 at accept+3.
REQ-037 Read 0x10 with PREADY delayed 3 ACCESS cycles, PRDATA=0xDEAD_BEEF -> PADDR stable throughout, rsp_rdata=0xDEAD_BEEF, rsp_err=0.
REQ-038 Two commands back-to-back (write 0x4, read 0x4) -> PSEL never drops between transfers, second SETUP immediately follows first ACCESS.
REQ-039 TIMEOUT=4, PREADY held 0 -> abort after 4 ACCESS cycles, rsp_err=1, PSEL=0 next cycle; PREADY rising at cycle 4 -> rsp_err=0.
REQ-040 PRESETn pulsed low during ACCESS -> all outputs 0 immediately, no rsp_valid; new command after release completes normally.
REQ-041 Loopback against apb completer: 64 random write/read pairs -> every read returns last written data.
